// File: rtl/sevenseg_pkg.sv
// Shared segment types and the hex-to-segment table for the multiplexed seven-segment scanner.
// Segment bit order is {g,f,e,d,c,b,a}, active-low.
package sevenseg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b1111111;

    localparam seg_t HEX_SEG [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

    function automatic seg_t hex_to_seg(input logic [3:0] nibble);
        return HEX_SEG[nibble];
    endfunction

endpackage

// File: rtl/sevenseg.sv
// Combinational hex nibble to active-low segment pattern lookup.
module sevenseg
    import sevenseg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output seg_t       seg_o
);

    assign seg_o = hex_to_seg(nibble_i);

endmodule

// File: rtl/sevenseg_scan.sv
// Multiplexed seven-segment scanner with frame-synchronous display update.
// Optional decimal points are enabled by defining SEVENSEG_DP_EN.
module sevenseg_scan
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_valid,
    input  logic [4*NUM_DIGITS-1:0] wr_data,
`ifdef SEVENSEG_DP_EN
    input  logic [NUM_DIGITS-1:0]   dp_in,
`endif
    output logic                    wr_ready,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic                    frame_done
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int DW = 4 * NUM_DIGITS;

    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DW-1:0]         shadow_q, shadow_d;
    logic [DW-1:0]         disp_q, disp_d;
    logic                  pending_q, pending_d;
    logic                  frame_done_q;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    seg_t                  seg_q, seg_d;
    seg_t                  seg_lut;
    logic [NUM_DIGITS-1:0] onehot;
    logic                  tick, wrap, accept;

    sevenseg u_sevenseg (
        .nibble_i (disp_q[{idx_q, 2'b00} +: 4]),
        .seg_o    (seg_lut)
    );

    assign onehot = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_q;

    always_comb begin
        tick      = (presc_q == PW'(REFRESH_DIV - 1));
        wrap      = tick && (idx_q == IW'(NUM_DIGITS - 1));
        accept    = wr_valid && !pending_q;
        presc_d   = tick ? '0 : presc_q + 1'b1;
        idx_d     = idx_q;
        if (tick) begin
            idx_d = wrap ? '0 : idx_q + 1'b1;
        end
        shadow_d  = accept ? wr_data : shadow_q;
        // The copy only uses a value that was already pending before this wrap,
        // so a write landing on the wrap cycle waits a full frame.
        disp_d    = (wrap && pending_q) ? shadow_q : disp_q;
        pending_d = pending_q;
        if (wrap && pending_q) begin
            pending_d = 1'b0;
        end else if (accept) begin
            pending_d = 1'b1;
        end
        an_d      = ~(onehot & digit_en);
        seg_d     = digit_en[idx_q] ? seg_lut : SEG_BLANK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q      <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            disp_q       <= '0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            an_q         <= '1;
            seg_q        <= SEG_BLANK;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            disp_q       <= disp_d;
            pending_q    <= pending_d;
            frame_done_q <= wrap;
            an_q         <= an_d;
            seg_q        <= seg_d;
        end
    end

`ifdef SEVENSEG_DP_EN
    logic [NUM_DIGITS-1:0] dp_shadow_q, dp_disp_q;
    logic                  dp_n_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_shadow_q <= '0;
            dp_disp_q   <= '0;
            dp_n_q      <= 1'b1;
        end else begin
            if (accept) begin
                dp_shadow_q <= dp_in;
            end
            if (wrap && pending_q) begin
                dp_disp_q <= dp_shadow_q;
            end
            dp_n_q <= ~(digit_en[idx_q] & dp_disp_q[idx_q]);
        end
    end

    assign dp_n = dp_n_q;
`else
    assign dp_n = 1'b1;
`endif

    assign wr_ready   = !pending_q;
    assign an_n       = an_q;
    assign seg_n      = seg_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Directed self-checking bench for sevenseg_scan with NUM_DIGITS=4, REFRESH_DIV=4.
module tb_sevenseg_scan;

    localparam int ND = 4;
    localparam int RD = 4;
`ifdef SEVENSEG_DP_EN
    localparam logic DP0_EXP = 1'b0;
`else
    localparam logic DP0_EXP = 1'b1;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_valid = 1'b0;
    logic [4*ND-1:0] wr_data = '0;
    logic          wr_ready;
    logic [ND-1:0] digit_en = '1;
    logic [ND-1:0] an_n;
    logic [6:0]    seg_n;
    logic          dp_n;
    logic          frame_done;
`ifdef SEVENSEG_DP_EN
    logic [ND-1:0] dp_in = 4'b0001;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    sevenseg_scan #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
`ifdef SEVENSEG_DP_EN
        .dp_in      (dp_in),
`endif
        .wr_ready   (wr_ready),
        .digit_en   (digit_en),
        .an_n       (an_n),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .frame_done (frame_done)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pins(input string tag, input logic [3:0] an_e, input logic [6:0] seg_e,
                            input logic dp_e);
        chk({tag, ".an_n"},  32'(an_n),  32'(an_e));
        chk({tag, ".seg_n"}, 32'(seg_n), 32'(seg_e));
        chk({tag, ".dp_n"},  32'(dp_n),  32'(dp_e));
    endtask

    initial begin
        // In reset: everything off, ready to accept.
        step(1);
        chk_pins("rst", 4'b1111, 7'b1111111, 1'b1);
        chk("rst.wr_ready", 32'(wr_ready), 32'd1);
        chk("rst.frame_done", 32'(frame_done), 32'd0);
        rst_n = 1'b1;

        // Edges counted from release; digit k shown after edges 4k+1 .. 4k+4.
        step(1);   // edge 1
        chk_pins("scan0", 4'b1110, 7'b1000000, 1'b1);
        step(4);   // edge 5
        chk_pins("scan1", 4'b1101, 7'b1000000, 1'b1);
        step(4);   // edge 9
        chk_pins("scan2", 4'b1011, 7'b1000000, 1'b1);
        step(4);   // edge 13
        chk_pins("scan3", 4'b0111, 7'b1000000, 1'b1);
        chk("scan3.frame_done", 32'(frame_done), 32'd0);
        step(3);   // edge 16: wrap
        chk("wrap1.frame_done", 32'(frame_done), 32'd1);
        step(1);   // edge 17
        chk("wrap1.frame_done_end", 32'(frame_done), 32'd0);
        chk_pins("frame2.d0", 4'b1110, 7'b1000000, 1'b1);

        // Mid-frame write.
        wr_valid = 1'b1;
        wr_data  = 16'h1234;
        step(1);   // edge 18
        chk("wr.ready_low", 32'(wr_ready), 32'd0);
        wr_data  = 16'h5678;   // offered while not ready: must be ignored
        step(2);   // edge 20
        wr_valid = 1'b0;
        step(1);   // edge 21
        chk_pins("hold.d1", 4'b1101, 7'b1000000, 1'b1);
        step(10);  // edge 31
        chk("hold.ready_low", 32'(wr_ready), 32'd0);
        step(1);   // edge 32: wrap applies 1234
        chk("wrap2.frame_done", 32'(frame_done), 32'd1);
        chk_pins("wrap2.d3_old", 4'b0111, 7'b1000000, 1'b1);
        chk("wrap2.ready", 32'(wr_ready), 32'd1);
        step(1);   // edge 33
        chk_pins("new.d0_4", 4'b1110, 7'b0011001, DP0_EXP);
        chk("new.frame_done_end", 32'(frame_done), 32'd0);
        step(4);   // edge 37
        chk_pins("new.d1_3", 4'b1101, 7'b0110000, 1'b1);
        step(4);   // edge 41
        chk_pins("new.d2_2", 4'b1011, 7'b0100100, 1'b1);
        step(4);   // edge 45
        chk_pins("new.d3_1", 4'b0111, 7'b1111001, 1'b1);

        // Write coincident with the wrap cycle (edge 48).
        step(2);   // edge 47
        wr_valid = 1'b1;
        wr_data  = 16'hABCD;
        step(1);   // edge 48
        wr_valid = 1'b0;
        chk("coin.frame_done", 32'(frame_done), 32'd1);
        chk("coin.ready_low", 32'(wr_ready), 32'd0);
        step(1);   // edge 49
        chk_pins("coin.d0_old", 4'b1110, 7'b0011001, DP0_EXP);
        step(16);  // edge 65
        chk_pins("coin.d0_D", 4'b1110, 7'b0100001, DP0_EXP);
        chk("coin.ready", 32'(wr_ready), 32'd1);
        step(12);  // edge 77
        chk_pins("coin.d3_A", 4'b0111, 7'b0001000, 1'b1);

        // Digit blanking.
        digit_en = 4'b1010;
        step(4);   // edge 81
        chk_pins("blank.d0", 4'b1111, 7'b1111111, 1'b1);
        step(4);   // edge 85
        chk_pins("blank.d1_C", 4'b1101, 7'b1000110, 1'b1);
        step(4);   // edge 89
        chk_pins("blank.d2", 4'b1111, 7'b1111111, 1'b1);
        step(4);   // edge 93
        chk_pins("blank.d3_A", 4'b0111, 7'b0001000, 1'b1);
        digit_en = 4'b1111;

        // Reset while a write is pending.
        wr_valid = 1'b1;
        wr_data  = 16'h5555;
        step(1);   // edge 94
        wr_valid = 1'b0;
        chk("rst2.pending", 32'(wr_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_pins("rst2.async", 4'b1111, 7'b1111111, 1'b1);
        chk("rst2.ready", 32'(wr_ready), 32'd1);
        chk("rst2.frame_done", 32'(frame_done), 32'd0);
        step(2);
        rst_n = 1'b1;
        step(1);
        chk_pins("rst2.d0_zero", 4'b1110, 7'b1000000, 1'b1);
        chk("rst2.ready_after", 32'(wr_ready), 32'd1);
        step(4);
        chk_pins("rst2.d1_zero", 4'b1101, 7'b1000000, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
